conv_window_scheduler: RTL and testbench

Sequences the convolution datapath over a full input image. It sweeps a KxK window across an IMG_W x IMG_H row-major matrix in the input RAM and issues one RAM/ROM read pair per tap. It marks the tap stream for the MAC datapath, waits for the datapath's accumulate-complete pulse, and then pushes one result per window position into the result FIFO. Start, busy and done run on a single handshake driven from an external pin or microcontroller.

---
 rtl/conv_window_scheduler_pkg.sv | 29 ++
 rtl/conv_window_scheduler_if.sv | 34 +++
 rtl/conv_window_scheduler_addr_gen.sv | 63 ++++++
 rtl/conv_window_scheduler.sv | 174 +++++++++++++++++
 tb/tb_conv_window_scheduler.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_window_scheduler_pkg.sv
// Shared types and constants for the convolution window scheduler:
// FSM state encoding, default geometry and output-size derivation.
package conv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_WAIT_ACC = 3'd2,
        ST_STORE    = 3'd3,
        ST_DONE     = 3'd4
    } state_e;

    localparam int DEF_IMG_W  = 18;
    localparam int DEF_IMG_H  = 18;
    localparam int DEF_K      = 3;
    localparam int DEF_ADDR_W = 10;
    localparam int DEF_COEF_W = 4;

    // Number of valid window positions along one image dimension.
    function automatic int out_dim(input int img, input int k);
        return img - k + 1;
    endfunction

    // Counter width able to index n positions; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/conv_window_scheduler_if.sv
// Handshake and memory-read bundle between the window scheduler (master)
// and its surroundings: control pins, RAM/ROM read ports, MAC and FIFO.
interface conv_window_scheduler_if
    import conv_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int COEF_W = DEF_COEF_W
);
    logic              start;
    logic              busy;
    logic              done;
    logic              ram_en;
    logic [ADDR_W-1:0] ram_addr;
    logic              rom_en;
    logic [COEF_W-1:0] rom_addr;
    logic              tap_valid;
    logic              tap_first;
    logic              tap_last;
    logic              acc_done;
    logic              fifo_full;
    logic              fifo_wr_en;

    modport master (
        input  start, acc_done, fifo_full,
        output busy, done, ram_en, ram_addr, rom_en, rom_addr,
               tap_valid, tap_first, tap_last, fifo_wr_en
    );

    modport slave (
        output start, acc_done, fifo_full,
        input  busy, done, ram_en, ram_addr, rom_en, rom_addr,
               tap_valid, tap_first, tap_last, fifo_wr_en
    );
endinterface

// File: rtl/conv_window_scheduler_addr_gen.sv
// Input-RAM address generator: window base plus in-window row and column
// offsets, all maintained with adders so no multiplier is needed.
module window_addr_gen
    import conv_pkg::*;
#(
    parameter int IMG_W  = DEF_IMG_W,
    parameter int K      = DEF_K,
    parameter int OUT_W  = out_dim(DEF_IMG_W, DEF_K),
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int COEF_W = DEF_COEF_W,
    parameter int COL_W  = cnt_w(OUT_W)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              step,
    input  logic              advance,
    input  logic [COEF_W-1:0] tap,
    input  logic [COL_W-1:0]  col,
    output logic [ADDR_W-1:0] ram_addr
);
    localparam logic [COEF_W-1:0] LAST_TAP  = COEF_W'(K * K - 1);
    localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(OUT_W - 1);
    localparam logic [ADDR_W-1:0] J_LAST    = ADDR_W'(K - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(IMG_W);
    // Moving from the last column to the next row start skips K-1 words plus one.
    localparam logic [ADDR_W-1:0] WRAP_STEP = ADDR_W'(K);

    logic [ADDR_W-1:0] base_r;
    logic [ADDR_W-1:0] row_off_r;
    logic [ADDR_W-1:0] col_off_r;

    // Base/offset registers: offsets walk the taps, base walks the windows.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            base_r    <= {ADDR_W{1'b0}};
            row_off_r <= {ADDR_W{1'b0}};
            col_off_r <= {ADDR_W{1'b0}};
        end else if (clear) begin
            base_r    <= {ADDR_W{1'b0}};
            row_off_r <= {ADDR_W{1'b0}};
            col_off_r <= {ADDR_W{1'b0}};
        end else begin
            if (step) begin
                if (tap == LAST_TAP) begin
                    row_off_r <= {ADDR_W{1'b0}};
                    col_off_r <= {ADDR_W{1'b0}};
                end else if (col_off_r == J_LAST) begin
                    row_off_r <= row_off_r + ROW_STEP;
                    col_off_r <= {ADDR_W{1'b0}};
                end else begin
                    col_off_r <= col_off_r + ADDR_W'(1);
                end
            end
            if (advance) begin
                base_r <= base_r + ((col == LAST_COL) ? WRAP_STEP : ADDR_W'(1));
            end
        end
    end

    assign ram_addr = base_r + row_off_r + col_off_r;

endmodule

// File: rtl/conv_window_scheduler.sv
// Sweeps a KxK window over the input image, issues one RAM/ROM read per tap,
// waits for the MAC result and writes one FIFO entry per window position.
module conv_window_scheduler
    import conv_pkg::*;
#(
    parameter int IMG_W  = DEF_IMG_W,
    parameter int IMG_H  = DEF_IMG_H,
    parameter int K      = DEF_K,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int COEF_W = DEF_COEF_W
) (
    input  logic                     clk,
    input  logic                     reset,
    conv_window_scheduler_if.master  bus
);
    localparam int OUT_W = out_dim(IMG_W, K);
    localparam int OUT_H = out_dim(IMG_H, K);
    localparam int COL_W = cnt_w(OUT_W);
    localparam int ROW_W = cnt_w(OUT_H);

    localparam logic [COEF_W-1:0] LAST_TAP = COEF_W'(K * K - 1);
    localparam logic [COL_W-1:0]  LAST_COL = COL_W'(OUT_W - 1);
    localparam logic [ROW_W-1:0]  LAST_ROW = ROW_W'(OUT_H - 1);

    state_e             state_r;
    state_e             state_nx;
    logic [COEF_W-1:0]  tap_r;
    logic [COL_W-1:0]   col_r;
    logic [ROW_W-1:0]   row_r;
    logic               tap_valid_r;
    logic               tap_first_r;
    logic               tap_last_r;

    logic               load_s;
    logic               step_s;
    logic               adv_s;
    logic               wr_s;
    logic               fetch_s;
    logic               last_pos_s;
    logic [ADDR_W-1:0]  addr_s;

    assign fetch_s    = (state_r == ST_FETCH);
    assign last_pos_s = (row_r == LAST_ROW) && (col_r == LAST_COL);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // Next-state and strobe decode; acc_done only matters in WAIT_ACC.
    always_comb begin
        state_nx = state_r;
        load_s   = 1'b0;
        step_s   = 1'b0;
        adv_s    = 1'b0;
        wr_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    load_s   = 1'b1;
                    state_nx = ST_FETCH;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_FETCH: begin
                step_s = 1'b1;
                if (tap_r == LAST_TAP) begin
                    state_nx = ST_WAIT_ACC;
                end else begin
                    state_nx = ST_FETCH;
                end
            end
            ST_WAIT_ACC: begin
                if (bus.acc_done) begin
                    state_nx = ST_STORE;
                end else begin
                    state_nx = ST_WAIT_ACC;
                end
            end
            ST_STORE: begin
                if (bus.fifo_full) begin
                    state_nx = ST_STORE;
                end else begin
                    wr_s  = 1'b1;
                    adv_s = 1'b1;
                    if (last_pos_s) begin
                        state_nx = ST_DONE;
                    end else begin
                        state_nx = ST_FETCH;
                    end
                end
            end
            ST_DONE: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // Tap, column and row counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tap_r <= {COEF_W{1'b0}};
            col_r <= {COL_W{1'b0}};
            row_r <= {ROW_W{1'b0}};
        end else if (load_s) begin
            tap_r <= {COEF_W{1'b0}};
            col_r <= {COL_W{1'b0}};
            row_r <= {ROW_W{1'b0}};
        end else begin
            if (step_s) begin
                tap_r <= (tap_r == LAST_TAP) ? {COEF_W{1'b0}} : tap_r + COEF_W'(1);
            end
            if (adv_s) begin
                if (col_r == LAST_COL) begin
                    col_r <= {COL_W{1'b0}};
                    row_r <= row_r + ROW_W'(1);
                end else begin
                    col_r <= col_r + COL_W'(1);
                end
            end
        end
    end

    // Tap markers delayed one cycle to line up with RAM/ROM read data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tap_valid_r <= 1'b0;
            tap_first_r <= 1'b0;
            tap_last_r  <= 1'b0;
        end else begin
            tap_valid_r <= fetch_s;
            tap_first_r <= fetch_s && (tap_r == {COEF_W{1'b0}});
            tap_last_r  <= fetch_s && (tap_r == LAST_TAP);
        end
    end

    window_addr_gen #(
        .IMG_W  (IMG_W),
        .K      (K),
        .OUT_W  (OUT_W),
        .ADDR_W (ADDR_W),
        .COEF_W (COEF_W),
        .COL_W  (COL_W)
    ) u_addr_gen (
        .clk      (clk),
        .reset    (reset),
        .clear    (load_s),
        .step     (step_s),
        .advance  (adv_s),
        .tap      (tap_r),
        .col      (col_r),
        .ram_addr (addr_s)
    );

    assign bus.busy       = (state_r != ST_IDLE);
    assign bus.done       = (state_r == ST_DONE);
    assign bus.ram_en     = fetch_s;
    assign bus.rom_en     = fetch_s;
    assign bus.ram_addr   = fetch_s ? addr_s : {ADDR_W{1'b0}};
    assign bus.rom_addr   = fetch_s ? tap_r : {COEF_W{1'b0}};
    assign bus.tap_valid  = tap_valid_r;
    assign bus.tap_first  = tap_first_r;
    assign bus.tap_last   = tap_last_r;
    assign bus.fifo_wr_en = wr_s;

endmodule

// File: tb/tb_conv_window_scheduler.sv
// Self-checking bench for conv_window_scheduler: a default 18x18/K=3 instance
// and a 5x5/K=2 instance, checked against an arithmetic window/tap model.
module tb_conv_window_scheduler;

    localparam int IW   = 18;
    localparam int KS   = 3;
    localparam int NT   = KS * KS;
    localparam int OW   = IW - KS + 1;
    localparam int NPOS = OW * OW;
    localparam int SW   = 5;
    localparam int SK   = 2;
    localparam int SOW  = SW - SK + 1;
    localparam int SNPOS = SOW * SOW;
    localparam int SNT  = SK * SK;

    logic clk;
    logic reset;

    conv_window_scheduler_if #(.ADDR_W(10), .COEF_W(4)) bus ();
    conv_window_scheduler_if #(.ADDR_W(5),  .COEF_W(2)) bus_s ();

    conv_window_scheduler #(.IMG_W(IW), .IMG_H(IW), .K(KS), .ADDR_W(10), .COEF_W(4)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    conv_window_scheduler #(.IMG_W(SW), .IMG_H(SW), .K(SK), .ADDR_W(5), .COEF_W(2)) dut_s (
        .clk(clk), .reset(reset), .bus(bus_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Window w (row-major over output positions), tap t (row-major inside window).
    function automatic int exp_addr(input int w, input int t, input int iw, input int k);
        int ow;
        ow = iw - k + 1;
        return ((w / ow) + (t / k)) * iw + (w % ow) + (t % k);
    endfunction

    int win_idx = 0, tap_idx = 0, vtap = 0, wr_count = 0, acc_cnt = 0, acc_delay = 0;
    bit acc_seen = 1'b0, spur_en = 1'b0;
    int base_seen[NPOS];
    int w0_addr[NT];
    int last_addr = 0;

    // Reference monitor and MAC responder for the default instance.
    always @(negedge clk) begin
        if (!reset) begin
            win_idx = 0; tap_idx = 0; vtap = 0; wr_count = 0; acc_cnt = 0; acc_seen = 1'b0;
            bus.acc_done = 1'b0;
        end else begin
            if (bus.start && !bus.busy) begin
                win_idx = 0; tap_idx = 0; vtap = 0; wr_count = 0; acc_cnt = 0; acc_seen = 1'b0;
            end
            if (bus.fifo_wr_en) begin
                check_eq("taps_per_win", 32'(tap_idx), 32'(NT));
                check_eq("acc_before_wr", 32'(acc_seen), 32'd1);
                check_eq("wr_while_full", 32'(bus.fifo_full), 32'd0);
                win_idx++; tap_idx = 0; acc_seen = 1'b0; wr_count++;
            end
            if (bus.ram_en) begin
                check_eq("ram_addr", 32'(bus.ram_addr), 32'(exp_addr(win_idx, tap_idx, IW, KS) % 1024));
                check_eq("rom_addr", 32'(bus.rom_addr), 32'(tap_idx));
                check_eq("rom_en", 32'(bus.rom_en), 32'd1);
                if (tap_idx == 0 && win_idx < NPOS) base_seen[win_idx] = int'(bus.ram_addr);
                if (win_idx == 0 && tap_idx < NT) w0_addr[tap_idx] = int'(bus.ram_addr);
                last_addr = int'(bus.ram_addr);
                tap_idx++;
            end
            if (bus.tap_valid) begin
                check_eq("tap_first", 32'(bus.tap_first), 32'(vtap == 0));
                check_eq("tap_last", 32'(bus.tap_last), 32'(vtap == NT - 1));
                vtap = (vtap + 1) % NT;
            end
            bus.acc_done = 1'b0;
            if (acc_cnt > 0) begin
                acc_cnt--;
                if (acc_cnt == 0) begin
                    bus.acc_done = 1'b1;
                    acc_seen = 1'b1;
                end
            end
            if (bus.tap_valid && bus.tap_last) begin
                if (acc_delay == 0) begin
                    bus.acc_done = 1'b1;
                    acc_seen = 1'b1;
                end else begin
                    acc_cnt = acc_delay;
                end
            end
            if (spur_en && bus.ram_en && tap_idx == 4) bus.acc_done = 1'b1;
        end
    end

    int s_addr_q[$];
    int s_wr = 0;

    // Recorder and immediate MAC responder for the small instance.
    always @(negedge clk) begin
        if (!reset) begin
            s_addr_q.delete(); s_wr = 0; bus_s.acc_done = 1'b0;
        end else begin
            if (bus_s.start && !bus_s.busy) begin
                s_addr_q.delete(); s_wr = 0;
            end
            if (bus_s.fifo_wr_en) s_wr++;
            if (bus_s.ram_en) s_addr_q.push_back(int'(bus_s.ram_addr));
            bus_s.acc_done = bus_s.tap_valid && bus_s.tap_last;
        end
    end

    task automatic wait_wr(input int n, input string tag);
        int k;
        for (k = 0; k < 3000; k++) begin
            if (wr_count >= n) break;
            @(posedge clk); #1;
        end
        if (k == 3000) check_eq({tag, "_timeout"}, 32'd1, 32'd0);
    endtask

    task automatic run_sweep(input bit rnd, input bit hold_start, output int done_cnt);
        bit prev_done, finished;
        done_cnt = 0; prev_done = 1'b0; finished = 1'b0;
        for (int n = 0; n < 20000; n++) begin
            @(posedge clk); #1;
            if (prev_done) begin
                check_eq("busy_after_done", 32'(bus.busy), 32'd0);
                finished = 1'b1;
                break;
            end
            if (rnd) begin
                acc_delay     = int'($urandom_range(0, 3));
                bus.fifo_full = ($urandom_range(0, 3) == 0);
            end
            if (bus.done) begin
                done_cnt++;
                check_eq("wr_at_done", 32'(wr_count), 32'(NPOS));
                prev_done = 1'b1;
                if (hold_start) bus.start = 1'b0;
            end
        end
        if (!finished) check_eq("sweep_timeout", 32'd1, 32'd0);
        bus.fifo_full = 1'b0;
    endtask

    initial begin
        int dcnt, idle_busy, idle_wr, k;
        int exp_w0[NT];
        int exp_s_last[SNT];
        exp_w0     = '{0, 1, 2, 18, 19, 20, 36, 37, 38};
        exp_s_last = '{18, 19, 23, 24};
        reset = 1'b0;
        bus.start = 1'b0; bus.fifo_full = 1'b0;
        bus_s.start = 1'b0; bus_s.fifo_full = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_outputs", 32'({bus.done, bus.ram_en, bus.rom_en, bus.ram_addr, bus.rom_addr,
                 bus.tap_valid, bus.tap_first, bus.tap_last, bus.fifo_wr_en}), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        check_eq("idle_busy", 32'(bus.busy), 32'd0);

        // First window with a two-cycle MAC delay, then a held-full FIFO on window 3.
        acc_delay = 2;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_wr(1, "win0");
        check_eq("win0_wr_count", 32'(wr_count), 32'd1);
        for (int i = 0; i < NT; i++) check_eq("win0_addr", 32'(w0_addr[i]), 32'(exp_w0[i]));
        acc_delay = 0;
        wait_wr(3, "win3");
        bus.fifo_full = 1'b1;
        for (k = 0; k < 100; k++) begin
            if (acc_seen) break;
            @(posedge clk); #1;
        end
        if (k == 100) check_eq("stall_timeout", 32'd1, 32'd0);
        for (int i = 0; i < 5; i++) begin
            check_eq("stall_wr", 32'(bus.fifo_wr_en), 32'd0);
            @(posedge clk); #1;
        end
        bus.fifo_full = 1'b0;
        #1;
        check_eq("release_wr", 32'(bus.fifo_wr_en), 32'd1);
        @(posedge clk); #1;
        check_eq("single_wr", 32'(bus.fifo_wr_en), 32'd0);
        run_sweep(1'b1, 1'b0, dcnt);
        check_eq("done_pulses", 32'(dcnt), 32'd1);
        check_eq("sweep_writes", 32'(wr_count), 32'(NPOS));
        check_eq("base_win1", 32'(base_seen[1]), 32'd1);
        check_eq("base_win4", 32'(base_seen[4]), 32'd4);
        check_eq("base_win16", 32'(base_seen[16]), 32'd18);
        check_eq("base_win255", 32'(base_seen[NPOS-1]), 32'd285);
        check_eq("last_addr", 32'(last_addr), 32'd323);

        // start held high plus spurious acc_done during FETCH.
        spur_en = 1'b1;
        bus.start = 1'b1;
        run_sweep(1'b1, 1'b1, dcnt);
        spur_en = 1'b0;
        check_eq("hold_done_pulses", 32'(dcnt), 32'd1);
        check_eq("hold_writes", 32'(wr_count), 32'(NPOS));
        idle_busy = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (bus.busy) idle_busy++;
        end
        check_eq("no_restart", 32'(idle_busy), 32'd0);

        // Asynchronous reset in the middle of window 10's fetch.
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (k = 0; k < 3000; k++) begin
            if (wr_count == 10 && bus.ram_en && tap_idx == 4) break;
            @(posedge clk); #1;
        end
        if (k == 3000) check_eq("win10_timeout", 32'd1, 32'd0);
        reset = 1'b0;
        #1;
        check_eq("abort_busy", 32'(bus.busy), 32'd0);
        check_eq("abort_ram_en", 32'(bus.ram_en), 32'd0);
        check_eq("abort_outputs", 32'({bus.done, bus.ram_en, bus.rom_en, bus.ram_addr, bus.rom_addr,
                 bus.tap_valid, bus.tap_first, bus.tap_last, bus.fifo_wr_en}), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        idle_busy = 0; idle_wr = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (bus.busy) idle_busy++;
            if (bus.fifo_wr_en) idle_wr++;
        end
        check_eq("post_rst_busy", 32'(idle_busy), 32'd0);
        check_eq("post_rst_wr", 32'(idle_wr), 32'd0);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check_eq("restart_addr", 32'(bus.ram_addr), 32'd0);
        check_eq("restart_ram_en", 32'(bus.ram_en), 32'd1);
        run_sweep(1'b1, 1'b0, dcnt);
        check_eq("restart_done", 32'(dcnt), 32'd1);
        check_eq("restart_writes", 32'(wr_count), 32'(NPOS));

        // Small 5x5 image with a 2x2 window.
        bus_s.start = 1'b1;
        @(posedge clk); #1;
        bus_s.start = 1'b0;
        for (k = 0; k < 2000; k++) begin
            if (bus_s.done) break;
            @(posedge clk); #1;
        end
        if (k == 2000) check_eq("small_timeout", 32'd1, 32'd0);
        check_eq("small_wr_at_done", 32'(s_wr), 32'(SNPOS));
        @(posedge clk); #1;
        check_eq("small_busy_after", 32'(bus_s.busy), 32'd0);
        check_eq("small_addr_count", 32'(s_addr_q.size()), 32'(SNPOS * SNT));
        if (s_addr_q.size() == SNPOS * SNT) begin
            for (int w = 0; w < SNPOS; w++)
                for (int t = 0; t < SNT; t++)
                    check_eq("small_addr", 32'(s_addr_q[w*SNT+t]), 32'(exp_addr(w, t, SW, SK)));
            for (int t = 0; t < SNT; t++)
                check_eq("small_last_win", 32'(s_addr_q[(SNPOS-1)*SNT+t]), 32'(exp_s_last[t]));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
